button_conditioner: RTL
=======================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter N_CH, default 4: number of independent button channels, range 1..16.
REQ-002 Parameter DEB_LEN, default 4: consecutive equal samples required to change the debounced level, range 2..16.
REQ-003 Parameter TICK_DIV, default 50000: clk cycles per sample tick, range 1..2^20 (50000 gives 2 kHz sampling at 100 MHz).
REQ-004 Parameter REPEAT_DELAY, default 1000: ticks from press to the first repeat pulse, range 1..65535.
REQ-005 Parameter REPEAT_PERIOD, default 200: ticks between subsequent repeat pulses, range 1..65535.
REQ-006 clk  input  1  sole clock; all state on its rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-low.
REQ-008 clear  input  1  synchronous clear of all channel state.
REQ-009 btn_in  input  N_CH  raw asynchronous button levels, one bit per channel.
REQ-010 level  output  N_CH  debounced level per channel.
REQ-011 press  output  N_CH  one-clk pulse when level rises.
REQ-012 release  output  N_CH  one-clk pulse when level falls.
REQ-013 repeat  output  N_CH  one-clk auto-repeat pulse while held (REQ-024).

Function
REQ-014 Each btn_in bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-015 The tick counter SHALL count 0..TICK_DIV-1 and wrap to 0; tick is high for exactly the one clk cycle in which the counter equals TICK_DIV-1; TICK_DIV=1 gives tick every cycle.
REQ-016 On each tick, every channel SHALL shift its synchronized input into a DEB_LEN-bit sample register.
REQ-017 level SHALL rise when all DEB_LEN samples are 1 and fall when all are 0, and SHALL hold in every other case (hysteresis, no chatter on mixed samples).
REQ-018 level SHALL change on the clk edge that completes the qualifying tick shift; press and release SHALL be registered and high in the same cycle as that level change, for exactly one cycle.
REQ-019 Worst-case latency from a stable btn_in edge to the level change SHALL be 2 + DEB_LEN*TICK_DIV clk cycles.
REQ-020 Channels SHALL be fully independent; simultaneous events on several channels SHALL each produce their own pulses in the same cycle.
REQ-021 clear SHALL zero the samples, level, repeat state and counters of every channel and the tick counter on the next edge, without emitting release; clear has priority over a coincident tick.
REQ-022 press and release SHALL never be high together on one channel.

Reset
REQ-023 While rst=0: tick counter 0, synchronizers 0, samples 0, level/press/release/repeat all 0, repeat FSM IDLE.

Configuration
REQ-024 Macro BTN_AUTOREPEAT_EN defined: per-channel FSM IDLE -> DELAY on press (tick count cleared); DELAY -> REPEAT, pulsing repeat, when REPEAT_DELAY ticks have elapsed; in REPEAT, pulse repeat every REPEAT_PERIOD ticks; any state -> IDLE in the cycle level falls; tick counts saturate, never wrap.
REQ-025 Macro BTN_AUTOREPEAT_EN undefined: repeat tied to 0, and no repeat FSM or counters synthesized.

Structure
REQ-026 Shared package btn_cond_pkg SHALL hold the repeat FSM state encodings (IDLE, DELAY, REPEAT) and the default parameter constants.
REQ-027 One sub-module, btn_channel (synchronizer, sampler, level, pulses, repeat FSM), SHALL be instantiated N_CH times by a generate loop; the tick counter is shared at the top.

Verification (N_CH=4, DEB_LEN=4, TICK_DIV=4, REPEAT_DELAY=3, REPEAT_PERIOD=2)
REQ-028 btn_in[0] 0->1 held -> level[0] rises and press[0] pulses once within 18 clk; no other channel moves.
REQ-029 btn_in[1] toggling every 5 clk for 100 clk from level 0 -> level[1] stays 0 with no press; toggling from level 1 -> level stays 1 with no release.
REQ-030 btn_in[2] held high for 60 clk with BTN_AUTOREPEAT_EN -> repeat[2] first 12 clk after press, then every 8 clk; release drops repeat immediately; without the macro, repeat stays 0.
REQ-031 btn_in=4'b1111 at once -> press=4'b1111 in one cycle; release 4'b1111 after all deassert.
REQ-032 rst pulled low mid-press and mid-repeat -> all outputs 0 asynchronously; after release of rst with btn_in held high, a fresh press after full debounce.
REQ-033 clear asserted with level[3]=1 on a tick cycle -> level[3]=0 next cycle, no release pulse; re-press after full debounce.

Source files
------------

// File: rtl/btn_cond_pkg.sv
// Shared constants and repeat-FSM state encoding for the button conditioner.
package btn_cond_pkg;

  localparam int unsigned DefNCh          = 4;
  localparam int unsigned DefDebLen       = 4;
  localparam int unsigned DefTickDiv      = 50000;
  localparam int unsigned DefRepeatDelay  = 1000;
  localparam int unsigned DefRepeatPeriod = 200;

  localparam int unsigned RptCntW = 16;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StDelay  = 2'd1,
    StRepeat = 2'd2
  } rpt_state_e;

endpackage

// File: rtl/button_conditioner_if.sv
// Button conditioner bus: raw buttons and clear in, debounced level and event pulses out.
interface button_conditioner_if #(
  parameter int unsigned N_CH = 4
);
  logic            clear;
  logic [N_CH-1:0] btn_in;
  logic [N_CH-1:0] level;
  logic [N_CH-1:0] press;
  logic [N_CH-1:0] release_pulse;
  logic [N_CH-1:0] repeat_pulse;

  modport master (
    output clear, btn_in,
    input  level, press, release_pulse, repeat_pulse
  );

  modport slave (
    input  clear, btn_in,
    output level, press, release_pulse, repeat_pulse
  );
endinterface

// File: rtl/btn_channel.sv
// One button channel: synchronizer, tick sampler, hysteretic level, pulses, optional
// auto-repeat FSM (enabled by BTN_AUTOREPEAT_EN).
module btn_channel
  import btn_cond_pkg::*;
#(
  parameter int unsigned DEB_LEN       = DefDebLen,
  parameter int unsigned REPEAT_DELAY  = DefRepeatDelay,
  parameter int unsigned REPEAT_PERIOD = DefRepeatPeriod
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  input  logic btn,
  output logic level,
  output logic press,
  output logic release_pulse,
  output logic repeat_pulse
);

  if (DEB_LEN < 2 || DEB_LEN > 16) begin : g_bad_deb
    $error("DEB_LEN out of range");
  end
  if (REPEAT_DELAY < 1 || REPEAT_DELAY > 65535 ||
      REPEAT_PERIOD < 1 || REPEAT_PERIOD > 65535) begin : g_bad_rpt
    $error("REPEAT_DELAY/REPEAT_PERIOD out of range");
  end

  logic               sync1_q, sync2_q;
  logic [DEB_LEN-1:0] samp_q, samp_d;
  logic               level_q, level_d;
  logic               press_q, release_q;
  logic               rise, fall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
    end
  end

  // Level only moves on a unanimous sample window; mixed windows hold it.
  always_comb begin
    samp_d  = samp_q;
    level_d = level_q;
    rise    = 1'b0;
    fall    = 1'b0;
    if (clear) begin
      samp_d  = '0;
      level_d = 1'b0;
    end else if (tick) begin
      samp_d = {samp_q[DEB_LEN-2:0], sync2_q};
      if (&samp_d && !level_q) begin
        level_d = 1'b1;
        rise    = 1'b1;
      end else if (~|samp_d && level_q) begin
        level_d = 1'b0;
        fall    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      samp_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      samp_q    <= samp_d;
      level_q   <= level_d;
      press_q   <= rise;
      release_q <= fall;
    end
  end

  assign level         = level_q;
  assign press         = press_q;
  assign release_pulse = release_q;

`ifdef BTN_AUTOREPEAT_EN
  rpt_state_e         state_q, state_d;
  logic [RptCntW-1:0] cnt_q, cnt_d;
  logic [RptCntW:0]   cnt_inc;
  logic               rpt_q, rpt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rpt_d   = 1'b0;
    cnt_inc = {1'b0, cnt_q} + 1'b1;
    if (clear || fall) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (rise) begin
            state_d = StDelay;
            cnt_d   = '0;
          end
        end
        StDelay: begin
          if (tick) begin
            if (cnt_inc >= (RptCntW+1)'(REPEAT_DELAY)) begin
              state_d = StRepeat;
              cnt_d   = '0;
              rpt_d   = 1'b1;
            end else if (!(&cnt_q)) begin
              cnt_d = cnt_inc[RptCntW-1:0];
            end
          end
        end
        StRepeat: begin
          if (tick) begin
            if (cnt_inc >= (RptCntW+1)'(REPEAT_PERIOD)) begin
              cnt_d = '0;
              rpt_d = 1'b1;
            end else if (!(&cnt_q)) begin
              cnt_d = cnt_inc[RptCntW-1:0];
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rpt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rpt_q   <= rpt_d;
    end
  end

  assign repeat_pulse = rpt_q;
`else
  assign repeat_pulse = 1'b0;
`endif

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel button debouncer with a shared sample tick; auto-repeat is built only
// when BTN_AUTOREPEAT_EN is defined.
module button_conditioner
  import btn_cond_pkg::*;
#(
  parameter int unsigned N_CH          = DefNCh,
  parameter int unsigned DEB_LEN       = DefDebLen,
  parameter int unsigned TICK_DIV      = DefTickDiv,
  parameter int unsigned REPEAT_DELAY  = DefRepeatDelay,
  parameter int unsigned REPEAT_PERIOD = DefRepeatPeriod
) (
  input logic                 clk,
  input logic                 rst,
  button_conditioner_if.slave bus
);

  if (N_CH < 1 || N_CH > 16 || TICK_DIV < 1 || TICK_DIV > (1 << 20)) begin : g_bad_top
    $error("N_CH/TICK_DIV out of range");
  end

  localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
  logic             tick;

  assign tick = (tick_cnt_q == TickW'(TICK_DIV - 1));

  always_comb begin
    tick_cnt_d = tick_cnt_q + TickW'(1);
    if (bus.clear || tick) tick_cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tick_cnt_q <= '0;
    else      tick_cnt_q <= tick_cnt_d;
  end

  logic [N_CH-1:0] level, press, release_pulse, repeat_pulse;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    btn_channel #(
      .DEB_LEN      (DEB_LEN),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .clear        (bus.clear),
      .tick         (tick),
      .btn          (bus.btn_in[i]),
      .level        (level[i]),
      .press        (press[i]),
      .release_pulse(release_pulse[i]),
      .repeat_pulse (repeat_pulse[i])
    );
  end

  assign bus.level         = level;
  assign bus.press         = press;
  assign bus.release_pulse = release_pulse;
  assign bus.repeat_pulse  = repeat_pulse;

endmodule
